// File: rtl/rx_iq_decim_pkg.sv
// rx_iq_decim_pkg: shared widths, ratio clamp and output packing for the rx I/Q decimator
package rx_iq_decim_pkg;
    localparam int IW       = 12;
    localparam int OW       = 16;
    localparam int MAX_LOG2 = 4;
    localparam int AW       = IW + MAX_LOG2;

    function automatic logic [2:0] k_eff(input logic [2:0] k);
        return (k > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : k;
    endfunction

    function automatic logic [MAX_LOG2-1:0] last_phase(input logic [2:0] k);
        return MAX_LOG2'((32'd1 << k) - 32'd1);
    endfunction

    function automatic logic [2*OW-1:0] pack_iq(input logic [IW-1:0] q, input logic [IW-1:0] i);
        return {{(OW-IW){q[IW-1]}}, q, {(OW-IW){i[IW-1]}}, i};
    endfunction
endpackage

// File: rtl/rx_lane_avg.sv
// rx_lane_avg: one lane's boxcar accumulator with round-half-up shift by 2^k
module rx_lane_avg
    import rx_iq_decim_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_acc,
    input  logic                 i_first,
    input  logic [2:0]           i_k,
    input  logic [IW-1:0]        i_din,
    output logic [IW-1:0]        o_avg
);
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_total;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_shift;
    logic [AW-1:0]        w_rnd;

    always_comb begin
        w_total = (i_first ? '0 : r_acc) + {{MAX_LOG2{i_din[IW-1]}}, i_din};
        w_rnd   = (i_k == 3'd0) ? '0 : AW'(1) << (i_k - 3'd1);
        w_sum   = w_total + w_rnd;
        w_shift = w_sum >>> i_k;
        o_avg   = w_shift[IW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_acc)
            r_acc <= w_total;
    end
endmodule

// File: rtl/rx_iq_decim.sv
// rx_iq_decim: decimate-by-2^k boxcar averager packing {sext(Q), sext(I)} for the DDR mover
module rx_iq_decim
    import rx_iq_decim_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IW-1:0]        rx_I,
    input  logic [IW-1:0]        rx_Q,
    input  logic                 rx_ce,
    input  logic                 enable,
    input  logic                 sync,
    input  logic [2:0]           dec_log2,
    output logic [2*OW-1:0]      dout,
    output logic                 dout_en,
    output logic [31:0]          blk_cnt
);
    logic [MAX_LOG2-1:0] r_phase;
    logic [MAX_LOG2-1:0] w_phase;
    logic [2:0]          r_k;
    logic [2:0]          w_k;
    logic [2*OW-1:0]     r_dout;
    logic                r_dout_en;
    logic [31:0]         r_blk_cnt;
    logic                w_acc;
    logic                w_first;
    logic                w_last;
    logic [IW-1:0]       w_avg_i;
    logic [IW-1:0]       w_avg_q;

    // sync restarts the block in the same cycle, so a coincident sample is the new first sample
    always_comb begin
        w_acc   = enable & rx_ce;
        w_phase = sync ? '0 : r_phase;
        w_first = (w_phase == '0);
        w_k     = w_first ? k_eff(dec_log2) : r_k;
        w_last  = w_acc & (w_phase == last_phase(w_k));
    end

    rx_lane_avg u_lane_i (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (~enable),
        .i_acc  (w_acc),
        .i_first(w_first),
        .i_k    (w_k),
        .i_din  (rx_I),
        .o_avg  (w_avg_i)
    );

    rx_lane_avg u_lane_q (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (~enable),
        .i_acc  (w_acc),
        .i_first(w_first),
        .i_k    (w_k),
        .i_din  (rx_Q),
        .o_avg  (w_avg_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= '0;
            r_k       <= '0;
            r_dout    <= '0;
            r_dout_en <= 1'b0;
            r_blk_cnt <= '0;
        end else if (!enable) begin
            r_phase   <= '0;
            r_dout_en <= 1'b0;
        end else begin
            r_dout_en <= w_last;
            if (w_acc) begin
                r_phase <= w_last ? '0 : w_phase + MAX_LOG2'(1);
                if (w_first)
                    r_k <= w_k;
            end else begin
                r_phase <= w_phase;
            end
            if (w_last) begin
                r_dout    <= pack_iq(w_avg_q, w_avg_i);
                r_blk_cnt <= r_blk_cnt + 32'd1;
            end
        end
    end

    assign dout    = r_dout;
    assign dout_en = r_dout_en;
    assign blk_cnt = r_blk_cnt;
endmodule

// File: tb/tb_rx_iq_decim.sv
// tb_rx_iq_decim: directed and random stimulus against a block-level averaging model
module tb_rx_iq_decim;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rx_I = '0;
    logic [11:0] rx_Q = '0;
    logic        rx_ce = 1'b0;
    logic        en = 1'b0;
    logic        sync = 1'b0;
    logic [2:0]  dec = '0;
    logic [31:0] dout;
    logic        dout_en;
    logic [31:0] blk_cnt;

    int          errs = 0;
    int          checks = 0;

    int          m_n = 0;
    int          m_k = 0;
    int          m_si = 0;
    int          m_sq = 0;
    logic [31:0] m_dout = '0;
    logic        m_en = 1'b0;
    logic [31:0] m_blk = '0;

    rx_iq_decim dut (
        .clk     (clk),
        .rst     (rst),
        .rx_I    (rx_I),
        .rx_Q    (rx_Q),
        .rx_ce   (rx_ce),
        .enable  (en),
        .sync    (sync),
        .dec_log2(dec),
        .dout    (dout),
        .dout_en (dout_en),
        .blk_cnt (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic model(input logic ce, input logic sy, input int si, input int sq);
        int half;
        int ai;
        int aq;
        if (!en) begin
            m_n  = 0;
            m_en = 1'b0;
        end else begin
            m_en = 1'b0;
            if (sy) m_n = 0;
            if (ce) begin
                if (m_n == 0) begin
                    m_k  = (dec > 3'd4) ? 4 : int'(dec);
                    m_si = 0;
                    m_sq = 0;
                end
                m_si += si;
                m_sq += sq;
                m_n++;
                if (m_n == (1 << m_k)) begin
                    half   = (m_k == 0) ? 0 : (1 << (m_k - 1));
                    ai     = (m_si + half) >>> m_k;
                    aq     = (m_sq + half) >>> m_k;
                    m_dout = {aq[15:0], ai[15:0]};
                    m_en   = 1'b1;
                    m_blk  = m_blk + 32'd1;
                    m_n    = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag);
        checks++;
        assert (dout_en === m_en) else begin
            errs++;
            $error("FAIL %s dout_en got %0b expected %0b", tag, dout_en, m_en);
        end
        checks++;
        assert (dout === m_dout) else begin
            errs++;
            $error("FAIL %s dout got %08h expected %08h", tag, dout, m_dout);
        end
        checks++;
        assert (blk_cnt === m_blk) else begin
            errs++;
            $error("FAIL %s blk_cnt got %0d expected %0d", tag, blk_cnt, m_blk);
        end
    endtask

    task automatic step(input string tag, input logic ce, input logic sy, input logic [11:0] i, input logic [11:0] q);
        rx_ce = ce;
        sync  = sy;
        rx_I  = i;
        rx_Q  = q;
        @(posedge clk);
        model(ce, sy, int'(signed'(i)), int'(signed'(q)));
        #1;
        check(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int j = 0; j < n; j++) step(tag, 1'b0, 1'b0, 12'(j), 12'(~j));
    endtask

    task automatic rnd(input string tag, input int n);
        for (int j = 0; j < n; j++) step(tag, 1'b1, 1'b0, 12'($urandom), 12'($urandom));
    endtask

    initial begin
        #12;
        check("reset");
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        dec = 3'd0;
        for (int j = 0; j < 6; j++) step("k0_full_scale", 1'b1, 1'b0, 12'h7FF, 12'h800);
        idle("k0_tail", 2);

        dec = 3'd2;
        for (int j = 0; j < 4; j++) begin
            step("k2_samples", 1'b1, 1'b0, 12'(j + 1), (j == 3) ? 12'hFFE : 12'hFFF);
            idle("k2_gap", 2);
        end

        dec = 3'd4;
        for (int j = 0; j < 16; j++) step("k4_extreme", 1'b1, 1'b0, 12'h7FF, 12'h800);
        rnd("k4_next_head", 5);
        dec = 3'd1;
        rnd("k4_next_tail", 11);
        rnd("k1_block", 4);
        idle("k1_tail", 1);

        dec = 3'd3;
        rnd("k3_partial", 5);
        step("k3_sync", 1'b1, 1'b1, 12'h123, 12'hEDC);
        for (int j = 0; j < 7; j++) begin
            step("k3_after_sync", 1'b1, 1'b0, 12'($urandom), 12'($urandom));
            if (j[0]) idle("k3_gap", 1);
        end

        dec = 3'd7;
        for (int j = 0; j < 16; j++) begin
            step("k7_clamped", 1'b1, 1'b0, 12'($urandom), 12'($urandom));
            if ($urandom_range(0, 2) == 0) idle("k7_gap", 1);
        end
        rnd("k7_partial", 6);
        en = 1'b0;
        rnd("disabled", 3);
        en = 1'b1;
        rnd("reenabled", 16);

        dec = 3'd2;
        rnd("pre_reset", 2);
        #2 rst = 1'b1;
        #1;
        m_n = 0; m_en = 1'b0; m_dout = '0; m_blk = '0;
        check("async_reset");
        @(negedge clk);
        rst = 1'b0;
        rnd("post_reset", 3);
        rnd("post_reset_done", 1);

        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 39) == 0) dec = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) en = ~en;
            step("random", 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                 12'($urandom), 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
